// File: rtl/msg_word_serializer_pkg.sv
// Shared constants for the message-to-word serializer: header field layout,
// word/message widths, default depth and FSM state encodings.
package msg_word_serializer_pkg;

    localparam int WORD_W            = 32;
    localparam int MSG_W             = 128;
    localparam int MAX_WORDS_DEFAULT = 4;

    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 16;
    localparam int METH_LSB = 16;
    localparam int METH_W   = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/msg_word_serializer.sv
// Accepts a whole 128-bit message and emits it as 32-bit words, header first,
// with downstream backpressure, zero-bubble back-to-back and sticky length error.
module msg_word_serializer
    import msg_word_serializer_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_enq__ENA,
    input  logic [MSG_W-1:0]  in_enq_v,
    output logic              in_enq__RDY,
    output logic              out_enq__ENA,
    output logic [WORD_W-1:0] out_enq_v,
    output logic              out_enq_last,
    input  logic              out_enq__RDY,
    output logic              err
);

    localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    logic [0:0]       state;
    logic [MSG_W-1:0] msg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic [LEN_W-1:0] len;
    logic             len_zero;
    logic             len_big;
    logic             on_last;
    logic             word_taken;
    logic             accept;

    assign len      = in_enq_v[LEN_LSB +: LEN_W];
    assign len_zero = (len == '0);
    assign len_big  = (len > MAX_LEN);

    assign on_last    = (state == ST_SEND) && (CNT_W'(idx) == (cnt - CNT_W'(1)));
    assign word_taken = (state == ST_SEND) && out_enq__RDY && !RST;
    assign accept     = in_enq__ENA && in_enq__RDY;

    // Outputs are forced quiet while reset is held so a half-sent message never leaks out.
    assign in_enq__RDY  = (state == ST_IDLE) || (on_last && out_enq__RDY);
    assign out_enq__ENA = word_taken;
    assign out_enq_last = word_taken && on_last;
    assign out_enq_v    = RST ? '0 : msg[WORD_W*idx +: WORD_W];
    assign err          = err_q;

    // A valid new message always wins over retiring the last word, which gives
    // the zero-bubble hand-over; a zero-length message falls through to retire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            msg   <= '0;
            idx   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept && (len_zero || len_big)) begin
                err_q <= 1'b1;
            end
            if (accept && !len_zero) begin
                state <= ST_SEND;
                msg   <= in_enq_v;
                idx   <= '0;
                cnt   <= len_big ? CNT_W'(MAX_WORDS) : len[CNT_W-1:0];
            end else if (word_taken) begin
                if (on_last) begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/msg_word_serializer.md
MSG_WORD_SERIALIZER -- requirements
Module: msg_word_serializer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4, meaning the largest message length in 32-bit words (header included).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in$enq__ENA  input  1  upstream message enqueue strobe.
REQ-005 SHALL have port in$enq$v  input  128  message: [15:0] length in words, [31:16] method number, [127:32] payload, LSW first.
REQ-006 SHALL have port in$enq__RDY  output  1  block can accept a message this cycle.
REQ-007 SHALL have port out$enq__ENA  output  1  downstream word enqueue strobe.
REQ-008 SHALL have port out$enq$v  output  32  current word.
REQ-009 SHALL have port out$enq$last  output  1  high with the final word of a message.
REQ-010 SHALL have port out$enq__RDY  input  1  downstream can accept a word.
REQ-011 SHALL have port err  output  1  sticky flag: malformed length seen.

Function
REQ-012 SHALL hold one 128-bit message register, a word index idx (2 bits for MAX_WORDS=4) and a word count cnt.
REQ-013 SHALL implement states IDLE and SEND; IDLE -> SEND on accepted message with valid length; SEND -> IDLE when the last word is accepted and no new message is accepted the same cycle.
REQ-014 SHALL drive in$enq__RDY = (state==IDLE) | (state==SEND & idx==cnt-1 & out$enq__RDY); callers enqueue only while RDY (ENA without RDY is a protocol violation and ignored).
REQ-015 SHALL drive out$enq__ENA = (state==SEND) & out$enq__RDY; out$enq$v = msg[32*idx+31 : 32*idx]; out$enq$last = out$enq__ENA & (idx==cnt-1).
REQ-016 SHALL present word 0 (header) the cycle after acceptance: latency exactly 1 cycle; one word per cycle while out$enq__RDY high.
REQ-017 SHALL hold idx and data unchanged while out$enq__RDY is low (stall, no word lost or duplicated).
REQ-018 SHALL increment idx on each accepted word; reset idx to 0 on last word.
REQ-019 SHALL, when the last word is accepted and a new message is enqueued the same cycle, load the new message, set idx=0, stay in SEND (zero-bubble back-to-back).
REQ-020 SHALL treat length 0 as malformed: drop the message, stay/return IDLE, set err.
REQ-021 SHALL treat length > MAX_WORDS as malformed: send MAX_WORDS words (truncate), set err.
REQ-022 SHALL never change err except to set it; cleared only by reset.
REQ-023 SHALL not inspect the method number; it passes in header word unchanged.

Reset
REQ-024 SHALL on RST high at a clock edge force state=IDLE, idx=0, cnt=0, err=0, message register=0, regardless of activity.
REQ-025 SHALL during and in the cycle after reset drive out$enq__ENA=0, out$enq$last=0, out$enq$v=0, in$enq__RDY=1 after reset deasserts; a message mid-transmission is discarded.

Structure
REQ-026 SHALL place the state enum, header field offsets/widths (LEN_LSB=0, LEN_W=16, METH_LSB=16) and MAX_WORDS default in the shared printf package.
REQ-027 SHALL be a single flat module; no sub-module is required (word mux inline).

Verification
REQ-028 SHALL cover single message: v={64'd0,32'hDEADBEEF,16'd0,16'd2}, out RDY=1 -> words 32'h00000002, 32'hDEADBEEF on consecutive cycles, last on 2nd, in RDY low for 1 cycle.
REQ-029 SHALL cover 4-word message with out RDY toggling 1,0,0,1,1,0,1 -> exactly 4 words in order {method=2,len=4}, a/b low, ..., no duplicates, last only on word 3.
REQ-030 SHALL cover back-to-back: two length-2 messages, second enqueued on first's last-word cycle -> 4 words on 4 consecutive cycles, no bubble.
REQ-031 SHALL cover malformed: length 0 -> no output words, err=1; then length 7 -> 4 words, err stays 1.
REQ-032 SHALL cover reset mid-message: RST asserted after word 1 of a 4-word message -> no further words, ENA=0, in RDY=1 next cycle, err=0.
